// File: rtl/tail_pkg.sv
// Shared types and constants for the tail-light sequencer: FSM state encoding,
// display state codes and the request-priority helper.
package tail_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HAZARD = 2'd1,
        S_LEFT   = 2'd2,
        S_RIGHT  = 2'd3
    } tail_state_t;

    localparam logic [2:0] IDLE_CODE   = 3'd0;
    localparam logic [2:0] HAZARD_CODE = 3'd1;
    localparam logic [2:0] LEFT_CODE   = 3'd2;
    localparam logic [2:0] RIGHT_CODE  = 3'd3;
    localparam logic [2:0] BRAKE_CODE  = 3'd4;

    // Hazard wins; both turn requests together also mean hazard.
    function automatic tail_state_t target_mode(input logic hazard_req,
                                                input logic left_req,
                                                input logic right_req);
        tail_state_t t;
        if (hazard_req || (left_req && right_req)) t = S_HAZARD;
        else if (left_req)                         t = S_LEFT;
        else if (right_req)                        t = S_RIGHT;
        else                                       t = S_IDLE;
        return t;
    endfunction

    function automatic logic [2:0] state_to_code(input tail_state_t s);
        logic [2:0] c;
        case (s)
            S_HAZARD: c = HAZARD_CODE;
            S_LEFT:   c = LEFT_CODE;
            S_RIGHT:  c = RIGHT_CODE;
            default:  c = IDLE_CODE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Animation-rate prescaler: one-cycle tick every TICK_DIV clocks, the first
// tick landing TICK_DIV cycles after synchronous reset is released.
module tick_gen #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)    count <= '0;
        else if (tick) count <= '0;
        else           count <= count + CW'(1);
    end

endmodule

// File: rtl/tail_light_seq.sv
// Tail-light sequencer: idle / hazard flash / left and right sweeps on two lamp banks.
// Optional brake overlay compiled in when TAIL_BRAKE_EN is defined.
module tail_light_seq
    import tail_pkg::*;
#(
    parameter int unsigned LEDS_PER_SIDE = 3,
    parameter int unsigned TICK_DIV      = 12_500_000,
    parameter int unsigned CUMULATIVE    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     left_req,
    input  logic                     right_req,
    input  logic                     hazard_req,
`ifdef TAIL_BRAKE_EN
    input  logic                     brake,
`endif
    output logic [LEDS_PER_SIDE-1:0] LEDR_L,
    output logic [LEDS_PER_SIDE-1:0] LEDR_R,
    output logic [2:0]               state_code
);

    localparam int unsigned SW = $clog2(LEDS_PER_SIDE + 1);

    if (LEDS_PER_SIDE < 1 || LEDS_PER_SIDE > 16) begin : g_bad_leds
        $error("tail_light_seq: LEDS_PER_SIDE must be 1..16");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("tail_light_seq: TICK_DIV must be at least 2");
    end

    logic                     tick;
    tail_state_t              state, state_d, target;
    logic [SW-1:0]            step, step_d;
    logic [LEDS_PER_SIDE-1:0] sweep_l, sweep_r;
    logic [LEDS_PER_SIDE-1:0] led_l_d, led_r_d;
    logic [2:0]               code_d;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign target = target_mode(hazard_req, left_req, right_req);

    always_comb begin
        state_d = state;
        step_d  = step;
        if (tick) begin
            if (target != state) begin
                state_d = target;
                step_d  = '0;
            end else begin
                case (state)
                    S_HAZARD: step_d = (step == SW'(1)) ? '0 : step + SW'(1);
                    S_LEFT,
                    S_RIGHT:  step_d = (step == SW'(LEDS_PER_SIDE)) ? '0 : step + SW'(1);
                    default:  step_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step  <= '0;
        end else begin
            state <= state_d;
            step  <= step_d;
        end
    end

    // Left pattern is built inner-to-outer from bit 0; right bank is its mirror image.
    always_comb begin
        sweep_l = '0;
        sweep_r = '0;
        for (int unsigned i = 0; i < LEDS_PER_SIDE; i++) begin
            if (CUMULATIVE != 0) sweep_l[i] = (i < 32'(step_d));
            else                 sweep_l[i] = (i + 1 == 32'(step_d));
        end
        for (int unsigned i = 0; i < LEDS_PER_SIDE; i++) begin
            sweep_r[LEDS_PER_SIDE-1-i] = sweep_l[i];
        end
    end

    // Outputs decode the next state so they land on the same edge that consumes the tick.
    always_comb begin
        led_l_d = '0;
        led_r_d = '0;
        code_d  = state_to_code(state_d);
        case (state_d)
            S_HAZARD: begin
                if (step_d != '0) begin
                    led_l_d = '1;
                    led_r_d = '1;
                end
            end
            S_LEFT:  led_l_d = sweep_l;
            S_RIGHT: led_r_d = sweep_r;
            default: ;
        endcase
`ifdef TAIL_BRAKE_EN
        // Brake is sampled every clock, not only on ticks.
        if (brake) begin
            case (state_d)
                S_IDLE: begin
                    led_l_d = '1;
                    led_r_d = '1;
                    code_d  = BRAKE_CODE;
                end
                S_LEFT:  led_r_d = '1;
                S_RIGHT: led_l_d = '1;
                default: ;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            LEDR_L     <= '0;
            LEDR_R     <= '0;
            state_code <= IDLE_CODE;
        end else begin
            LEDR_L     <= led_l_d;
            LEDR_R     <= led_r_d;
            state_code <= code_d;
        end
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq: walking (CUMULATIVE=0) and fill (CUMULATIVE=1)
// instances share stimulus; brake scenarios run only when TAIL_BRAKE_EN is defined.
module tb_tail_light_seq;

    localparam int unsigned NL  = 3;
    localparam int unsigned DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          left_req, right_req, hazard_req;
`ifdef TAIL_BRAKE_EN
    logic          brake;
`endif
    logic [NL-1:0] lw, rw, lf, rf;
    logic [2:0]    cw, cf;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tail_light_seq #(.LEDS_PER_SIDE(NL), .TICK_DIV(DIV), .CUMULATIVE(0)) u_walk (
        .clk        (clk),
        .rst_n      (rst_n),
        .left_req   (left_req),
        .right_req  (right_req),
        .hazard_req (hazard_req),
`ifdef TAIL_BRAKE_EN
        .brake      (brake),
`endif
        .LEDR_L     (lw),
        .LEDR_R     (rw),
        .state_code (cw)
    );

    tail_light_seq #(.LEDS_PER_SIDE(NL), .TICK_DIV(DIV), .CUMULATIVE(1)) u_fill (
        .clk        (clk),
        .rst_n      (rst_n),
        .left_req   (left_req),
        .right_req  (right_req),
        .hazard_req (hazard_req),
`ifdef TAIL_BRAKE_EN
        .brake      (brake),
`endif
        .LEDR_L     (lf),
        .LEDR_R     (rf),
        .state_code (cf)
    );

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag,
                             input logic [NL-1:0] e_lw, input logic [NL-1:0] e_rw,
                             input logic [NL-1:0] e_lf, input logic [NL-1:0] e_rf,
                             input logic [2:0] e_code);
        check({tag, ".walk_L"}, 16'(lw), 16'(e_lw));
        check({tag, ".walk_R"}, 16'(rw), 16'(e_rw));
        check({tag, ".walk_code"}, 16'(cw), 16'(e_code));
        check({tag, ".fill_L"}, 16'(lf), 16'(e_lf));
        check({tag, ".fill_R"}, 16'(rf), 16'(e_rf));
        check({tag, ".fill_code"}, 16'(cf), 16'(e_code));
    endtask

    initial begin
        rst_n      = 1'b0;
        left_req   = 1'b0;
        right_req  = 1'b0;
        hazard_req = 1'b0;
`ifdef TAIL_BRAKE_EN
        brake      = 1'b0;
`endif
        edges(3);
        check_all("reset", 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);

        // Release with left held: first tick consumed on the 4th edge.
        rst_n    = 1'b1;
        left_req = 1'b1;
        edges(3);
        check_all("pre_first_tick", 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
        edges(1);
        check_all("left_t1", 3'b000, 3'b000, 3'b000, 3'b000, 3'd2);
        edges(2);
        check_all("left_hold_mid", 3'b000, 3'b000, 3'b000, 3'b000, 3'd2);
        edges(2);
        check_all("left_t2", 3'b001, 3'b000, 3'b001, 3'b000, 3'd2);
        edges(4);
        check_all("left_t3", 3'b010, 3'b000, 3'b011, 3'b000, 3'd2);
        edges(4);
        check_all("left_t4", 3'b100, 3'b000, 3'b111, 3'b000, 3'd2);
        edges(4);
        check_all("left_t5_wrap", 3'b000, 3'b000, 3'b000, 3'b000, 3'd2);
        edges(4);
        check_all("left_t6", 3'b001, 3'b000, 3'b001, 3'b000, 3'd2);

        hazard_req = 1'b1;
        edges(4);
        check_all("haz_off", 3'b000, 3'b000, 3'b000, 3'b000, 3'd1);
        edges(4);
        check_all("haz_on", 3'b111, 3'b111, 3'b111, 3'b111, 3'd1);
        edges(4);
        check_all("haz_off2", 3'b000, 3'b000, 3'b000, 3'b000, 3'd1);
        edges(4);
        check_all("haz_on2", 3'b111, 3'b111, 3'b111, 3'b111, 3'd1);

        hazard_req = 1'b0;
        edges(4);
        check_all("left_restart", 3'b000, 3'b000, 3'b000, 3'b000, 3'd2);
        edges(4);
        check_all("left_restart_t2", 3'b001, 3'b000, 3'b001, 3'b000, 3'd2);

        right_req = 1'b1;
        edges(4);
        check_all("lr_haz_off", 3'b000, 3'b000, 3'b000, 3'b000, 3'd1);
        edges(4);
        check_all("lr_haz_on", 3'b111, 3'b111, 3'b111, 3'b111, 3'd1);
        edges(4);
        check_all("lr_haz_off2", 3'b000, 3'b000, 3'b000, 3'b000, 3'd1);

        left_req = 1'b0;
        edges(4);
        check_all("right_t1", 3'b000, 3'b000, 3'b000, 3'b000, 3'd3);
        edges(4);
        check_all("right_t2", 3'b000, 3'b100, 3'b000, 3'b100, 3'd3);
        edges(4);
        check_all("right_t3", 3'b000, 3'b010, 3'b000, 3'b110, 3'd3);
        edges(4);
        check_all("right_t4", 3'b000, 3'b001, 3'b000, 3'b111, 3'd3);
        edges(4);
        check_all("right_t5_wrap", 3'b000, 3'b000, 3'b000, 3'b000, 3'd3);
        edges(4);
        check_all("right_t6", 3'b000, 3'b100, 3'b000, 3'b100, 3'd3);
        edges(4);
        check_all("right_t7", 3'b000, 3'b010, 3'b000, 3'b110, 3'd3);

        // One-cycle reset mid sweep, request still held.
        edges(1);
        rst_n = 1'b0;
        edges(1);
        check_all("midsweep_reset", 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
        rst_n = 1'b1;
        edges(3);
        check_all("post_reset_pre_tick", 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
        edges(1);
        check_all("post_reset_t1", 3'b000, 3'b000, 3'b000, 3'b000, 3'd3);
        edges(4);
        check_all("post_reset_t2", 3'b000, 3'b100, 3'b000, 3'b100, 3'd3);

`ifdef TAIL_BRAKE_EN
        right_req = 1'b0;
        left_req  = 1'b1;
        edges(4);
        check_all("brk_left_t1", 3'b000, 3'b000, 3'b000, 3'b000, 3'd2);
        edges(4);
        check_all("brk_left_t2", 3'b001, 3'b000, 3'b001, 3'b000, 3'd2);
        brake = 1'b1;
        edges(1);
        check_all("brk_next_edge", 3'b001, 3'b111, 3'b001, 3'b111, 3'd2);
        edges(3);
        check_all("brk_left_t3", 3'b010, 3'b111, 3'b011, 3'b111, 3'd2);
        left_req = 1'b0;
        edges(4);
        check_all("brk_idle", 3'b111, 3'b111, 3'b111, 3'b111, 3'd4);
        hazard_req = 1'b1;
        edges(4);
        check_all("brk_haz_off", 3'b000, 3'b000, 3'b000, 3'b000, 3'd1);
        edges(4);
        check_all("brk_haz_on", 3'b111, 3'b111, 3'b111, 3'b111, 3'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
